// File: rtl/morse_pkg.sv
// Shared definitions for the Morse sender: FSM encoding, character codes and timing multipliers.
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MARK     = 3'd1,
        GAP      = 3'd2,
        CHAR_GAP = 3'd3,
        WORD_GAP = 3'd4
    } state_t;

    localparam int CNT_W = 27;

    localparam logic [5:0] CODE_SPACE     = 6'd36;
    localparam logic [5:0] CODE_MAX_VALID = 6'd36;

    localparam int DASH_UNITS       = 3;
    localparam int CHAR_GAP_UNITS   = 3;
    localparam int WORD_EXTRA_UNITS = 4;

endpackage

// File: rtl/morse_sender_if.sv
// Character request channel of the Morse sender, with status pulses returned to the requester.
interface morse_sender_if;
    // Handshake: a character transfers on the rising clk edge where char_valid && ready;
    // char_code must be stable while char_valid is high. ready is high only when idle,
    // done/err are single-cycle pulses, and a request seen while ready is low is dropped.
    logic       char_valid;
    logic [5:0] char_code;
    logic       ready;
    logic       done;
    logic       err;

    modport master (output char_valid, output char_code, input ready, input done, input err);
    modport slave  (input char_valid, input char_code, output ready, output done, output err);
endinterface

// File: rtl/morse_rom.sv
// Combinational ITU Morse table: code -> element count, pattern (LSB = first element, 1 = dash), valid.
module morse_rom
    import morse_pkg::*;
(
    input  logic [5:0] code,
    output logic [2:0] len,
    output logic [4:0] pattern,
    output logic       valid
);

    always_comb begin
        len     = 3'd0;
        pattern = 5'b00000;
        valid   = (code <= CODE_MAX_VALID);
        case (code)
            6'd0:  begin len = 3'd2; pattern = 5'b00010; end // A .-
            6'd1:  begin len = 3'd4; pattern = 5'b00001; end // B -...
            6'd2:  begin len = 3'd4; pattern = 5'b00101; end
            6'd3:  begin len = 3'd3; pattern = 5'b00001; end
            6'd4:  begin len = 3'd1; pattern = 5'b00000; end
            6'd5:  begin len = 3'd4; pattern = 5'b00100; end
            6'd6:  begin len = 3'd3; pattern = 5'b00011; end
            6'd7:  begin len = 3'd4; pattern = 5'b00000; end
            6'd8:  begin len = 3'd2; pattern = 5'b00000; end
            6'd9:  begin len = 3'd4; pattern = 5'b01110; end
            6'd10: begin len = 3'd3; pattern = 5'b00101; end
            6'd11: begin len = 3'd4; pattern = 5'b00010; end
            6'd12: begin len = 3'd2; pattern = 5'b00011; end
            6'd13: begin len = 3'd2; pattern = 5'b00001; end
            6'd14: begin len = 3'd3; pattern = 5'b00111; end
            6'd15: begin len = 3'd4; pattern = 5'b00110; end
            6'd16: begin len = 3'd4; pattern = 5'b01011; end
            6'd17: begin len = 3'd3; pattern = 5'b00010; end
            6'd18: begin len = 3'd3; pattern = 5'b00000; end
            6'd19: begin len = 3'd1; pattern = 5'b00001; end
            6'd20: begin len = 3'd3; pattern = 5'b00100; end
            6'd21: begin len = 3'd4; pattern = 5'b01000; end
            6'd22: begin len = 3'd3; pattern = 5'b00110; end
            6'd23: begin len = 3'd4; pattern = 5'b01001; end
            6'd24: begin len = 3'd4; pattern = 5'b01101; end
            6'd25: begin len = 3'd4; pattern = 5'b00011; end
            6'd26: begin len = 3'd5; pattern = 5'b11111; end // 0 -----
            6'd27: begin len = 3'd5; pattern = 5'b11110; end
            6'd28: begin len = 3'd5; pattern = 5'b11100; end
            6'd29: begin len = 3'd5; pattern = 5'b11000; end
            6'd30: begin len = 3'd5; pattern = 5'b10000; end
            6'd31: begin len = 3'd5; pattern = 5'b00000; end
            6'd32: begin len = 3'd5; pattern = 5'b00001; end
            6'd33: begin len = 3'd5; pattern = 5'b00011; end
            6'd34: begin len = 3'd5; pattern = 5'b00111; end
            6'd35: begin len = 3'd5; pattern = 5'b01111; end
            default: begin len = 3'd0; pattern = 5'b00000; end
        endcase
    end

endmodule

// File: rtl/morse_sender.sv
// Morse key sequencer: one character per request, elements timed by a single down-counter.
// Optional tone output is enabled with the MORSE_SENDER_TONE_EN macro.
module morse_sender
    import morse_pkg::*;
#(
    parameter int DIT_CYCLES = 12500000,
    parameter int TONE_HALF  = 25000
) (
    input  logic          clk,
    input  logic          reset_n,
    morse_sender_if.slave bus,
    output logic          key_out,
    output logic          tone_out,
    output state_t        state_dbg
);

    localparam logic [CNT_W-1:0] DIT_LOAD  = CNT_W'(DIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DASH_LOAD = CNT_W'(DASH_UNITS * DIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CHAR_LOAD = CNT_W'(CHAR_GAP_UNITS * DIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] WORD_LOAD = CNT_W'(WORD_EXTRA_UNITS * DIT_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [4:0]       pat, pat_nxt;
    logic [2:0]       len, len_nxt;
    logic             err_q, err_nxt;

    logic [2:0]       rom_len;
    logic [4:0]       rom_pat;
    logic             rom_valid;

    morse_rom u_rom (
        .code    (bus.char_code),
        .len     (rom_len),
        .pattern (rom_pat),
        .valid   (rom_valid)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            pat   <= '0;
            len   <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            pat   <= pat_nxt;
            len   <= len_nxt;
            err_q <= err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = (cnt == '0) ? '0 : cnt - CNT_W'(1);
        pat_nxt   = pat;
        len_nxt   = len;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.char_valid) begin
                    if (!rom_valid) begin
                        err_nxt = 1'b1;
                    end else if (bus.char_code == CODE_SPACE) begin
                        state_nxt = WORD_GAP;
                        cnt_nxt   = WORD_LOAD;
                    end else begin
                        state_nxt = MARK;
                        pat_nxt   = rom_pat;
                        len_nxt   = rom_len;
                        cnt_nxt   = rom_pat[0] ? DASH_LOAD : DIT_LOAD;
                    end
                end
            end
            MARK: begin
                if (cnt == '0) begin
                    // The pattern shifts here so GAP can pick the next element from bit 0.
                    if (len > 3'd1) begin
                        state_nxt = GAP;
                        cnt_nxt   = DIT_LOAD;
                        len_nxt   = len - 3'd1;
                        pat_nxt   = {1'b0, pat[4:1]};
                    end else begin
                        state_nxt = CHAR_GAP;
                        cnt_nxt   = CHAR_LOAD;
                    end
                end
            end
            GAP: begin
                if (cnt == '0) begin
                    state_nxt = MARK;
                    cnt_nxt   = pat[0] ? DASH_LOAD : DIT_LOAD;
                end
            end
            CHAR_GAP, WORD_GAP: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                    pat_nxt   = '0;
                    len_nxt   = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.ready = (state == IDLE);
    assign bus.done  = ((state == CHAR_GAP) || (state == WORD_GAP)) && (cnt == '0);
    assign bus.err   = err_q;
    assign key_out   = (state == MARK);
    assign state_dbg = state;

`ifdef MORSE_SENDER_TONE_EN
    logic [15:0] tone_cnt;
    logic        tone_q;

    always_ff @(posedge clk) begin
        if (!reset_n || !key_out) begin
            tone_cnt <= '0;
            tone_q   <= 1'b0;
        end else if (tone_cnt == 16'(TONE_HALF - 1)) begin
            tone_cnt <= '0;
            tone_q   <= ~tone_q;
        end else begin
            tone_cnt <= tone_cnt + 16'd1;
        end
    end

    // Gating keeps the tone silent on the first key-low cycle, before the register clears.
    assign tone_out = tone_q & key_out;
`else
    logic unused_tone_cfg;
    assign unused_tone_cfg = ^32'(TONE_HALF);
    assign tone_out        = 1'b0;
`endif

endmodule

// File: doc/morse_sender.md
MORSE_SENDER -- requirements
Module: morse_sender

Interface
REQ-001 Parameter DIT_CYCLES, default 12500000, clocks per Morse time unit (0.25 s at 50 MHz); minimum 2.
REQ-002 Parameter TONE_HALF, default 25000, clocks per half-period of the optional tone (1 kHz at 50 MHz).
REQ-003 Ports: one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  system clock, 50 MHz on the DE2-115, rising edge.
REQ-005 reset_n  in  1  synchronous active-low reset.
REQ-006 char_valid  in  1  request to send char_code.
REQ-007 char_code  in  6  0-25 = A-Z, 26-35 = 0-9, 36 = word space, 37-63 = invalid.
REQ-008 ready  out  1  high only in IDLE; a character is accepted on the clock edge where char_valid && ready.
REQ-009 key_out  out  1  Morse key, drives LED or buzzer, high during marks.
REQ-010 done  out  1  one-cycle pulse when a character or space, including its trailing gap, is complete.
REQ-011 err  out  1  one-cycle pulse when an invalid code is offered.
REQ-012 tone_out  out  1  square wave gated by key_out; present only under the configuration macro.

Function
REQ-013 The FSM states shall be IDLE, MARK, GAP, CHAR_GAP and WORD_GAP, with a registered state and a single 27-bit down-counter.
REQ-014 On accept of a valid letter or digit, the block shall latch the pattern (up to 5 bits, LSB first, 1 = dash) and the length (1-5), then enter MARK on the next cycle.
REQ-015 In MARK, key_out shall be 1 for DIT_CYCLES clocks for a dit or 3*DIT_CYCLES clocks for a dash.
REQ-016 After MARK, if elements remain, the block shall enter GAP for DIT_CYCLES clocks with key_out 0, shift the pattern and return to MARK.
REQ-017 After the last element, the block shall enter CHAR_GAP for 3*DIT_CYCLES clocks with key_out 0.
REQ-018 done shall pulse on the final CHAR_GAP cycle, and the block shall be in IDLE (ready = 1) on the following cycle.
REQ-019 On accept of code 36, the block shall enter WORD_GAP for 4*DIT_CYCLES clocks with key_out 0, pulse done on the final cycle, then go to IDLE; this gives 7 units total after a preceding character.
REQ-020 For codes 37-63 offered while ready, err shall pulse the following cycle, the state shall remain IDLE, ready shall stay 1 and key_out shall stay 0.
REQ-021 char_valid shall be ignored when ready = 0, with no queuing and no err.
REQ-022 key_out shall rise exactly 1 clock after the accepting edge; all outputs shall be registered or decoded from registered state only.
REQ-023 The lookup shall follow standard ITU Morse (e.g. A = .-, E = ., O = ---, 0 = -----, 5 = .....).

Reset
REQ-024 When reset_n = 0 at a rising edge, the block shall enter IDLE, clear the counter, pattern and length, and set key_out = 0, done = 0, err = 0, tone_out = 0 and ready = 1 on the next cycle.
REQ-025 Reset mid-character shall abort the transmission immediately with no done pulse.
REQ-026 Reset shall take priority over char_valid in the same cycle.

Configuration
REQ-027 With MORSE_SENDER_TONE_EN defined, a 16-bit tone counter shall toggle tone_out every TONE_HALF clocks while key_out = 1.
REQ-028 With MORSE_SENDER_TONE_EN defined, tone_out and the tone counter shall be held at 0 while key_out = 0.
REQ-029 Without MORSE_SENDER_TONE_EN, tone_out shall be tied to 0 and no tone logic shall be synthesized.

Structure
REQ-030 A shared package, morse_pkg, shall hold the state encoding, the code constants (CODE_SPACE = 36, CODE_MAX_VALID = 36) and the unit multipliers (DASH_UNITS = 3, CHAR_GAP_UNITS = 3, WORD_EXTRA_UNITS = 4).
REQ-031 The combinational code-to-{length, pattern, valid} table shall be a sub-module named morse_rom.

Verification (DIT_CYCLES = 4, TONE_HALF = 2)
REQ-032 Offer code 4 (E): key_out high 4 cycles, then low 12 cycles, then done pulses, then ready = 1.
REQ-033 Offer code 0 (A): key_out high 4, low 4, high 12, low 12, then done pulses; total 32 cycles from accept to IDLE.
REQ-034 Offer code 36 followed by code 40: key_out low for 16 cycles, done pulses, then err pulses for the invalid code with ready staying 1.
REQ-035 Offer code 14 (O), hold char_valid high with code 4 throughout: O is sent, E is accepted only after ready returns, with no err.
REQ-036 Assert reset_n = 0 during the second dash of O: next cycle key_out = 0 and ready = 1, with no done pulse.
REQ-037 With MORSE_SENDER_TONE_EN defined, send E: tone_out toggles every 2 cycles while key_out = 1 and is 0 otherwise.
